// File: rtl/loader_pkg.sv
// Shared types and helpers for the byte-stream program loader.
package loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SYNC  = 4'd1,
        ST_COUNT = 4'd2,
        ST_HI    = 4'd3,
        ST_LO    = 4'd4,
        ST_WRITE = 4'd5,
        ST_CHECK = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERROR = 4'd8
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] xor8(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle watchdog: reloads on clear or while disabled, counts down while enabled.
module loader_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Loading TIMEOUT-1 makes the FSM react on exactly the TIMEOUT-th idle edge.
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: reload, decrement, or saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = LOAD;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/program_loader.sv
// Frames UART bytes into instructions, writes them to text RAM and holds the CPU during the load.
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR    = 8,
    parameter int         CODE    = 4,
    parameter int         WORD    = ADDR + CODE,
    parameter logic [7:0] SYNC    = SYNC_BYTE,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic            rx_valid,
    input  logic [7:0]      rx_byte,
    output logic            program_write,
    output logic [ADDR-1:0] program_addr,
    output logic [WORD-1:0] program_cmd,
    output logic            cpu_hold,
    output logic            load_busy,
    output logic            load_done,
    output logic            load_error
);

    localparam logic [15:0] PAD_MASK = ~((16'd1 << WORD) - 16'd1);

    loader_state_t   state_q, state_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [WORD-1:0] cmd_q, cmd_d;
    logic            write_q, write_d;
    logic            hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [7:0]      chk_q, chk_d;
    logic [7:0]      hi_q, hi_d;
    logic [ADDR:0]   cnt_q, cnt_d;
    logic [7:0]      skid_q, skid_d;
    logic            skid_vld_q, skid_vld_d;

    logic            byte_vld_s;
    logic [7:0]      byte_s;
    logic [15:0]     word_s;
    logic            pad_bad_s;
    logic            tmr_en_s;
    logic            expired_s;

    // A byte held over from the WRITE cycle is always older than the live strobe.
    assign byte_vld_s = skid_vld_q || rx_valid;
    assign byte_s     = skid_vld_q ? skid_q : rx_byte;
    assign word_s     = {hi_q, byte_s};
    assign pad_bad_s  = |(word_s & PAD_MASK);
    assign tmr_en_s   = (state_q == ST_COUNT) || (state_q == ST_HI) || (state_q == ST_LO) ||
                        (state_q == ST_WRITE) || (state_q == ST_CHECK);

    loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (rx_valid),
        .en_i      (tmr_en_s),
        .expired_o (expired_s)
    );

    // frame FSM next-state and registered-output next values
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        write_d = 1'b0;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        chk_d   = chk_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_SYNC;
                    hold_d  = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    chk_d   = 8'h00;
                    addr_d  = {ADDR{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (load_start) begin
                    state_d = ST_SYNC;
                    chk_d   = 8'h00;
                    addr_d  = {ADDR{1'b0}};
                end else if (byte_vld_s && (byte_s == SYNC)) begin
                    state_d = ST_COUNT;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_COUNT: begin
                if (byte_vld_s) begin
                    cnt_d   = (byte_s[ADDR-1:0] == {ADDR{1'b0}}) ? {1'b1, {ADDR{1'b0}}}
                                                                 : {1'b0, byte_s[ADDR-1:0]};
                    chk_d   = xor8(chk_q, byte_s);
                    state_d = ST_HI;
                end else if (expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_HI: begin
                if (byte_vld_s) begin
                    hi_d    = byte_s;
                    chk_d   = xor8(chk_q, byte_s);
                    state_d = ST_LO;
                end else if (expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_LO: begin
                if (byte_vld_s) begin
                    chk_d = xor8(chk_q, byte_s);
                    if (pad_bad_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        cmd_d   = word_s[WORD-1:0];
                        write_d = 1'b1;
                        state_d = ST_WRITE;
                    end
                end else if (expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + ADDR'(1);
                cnt_d  = cnt_q - (ADDR+1)'(1);
                if (cnt_q == (ADDR+1)'(1)) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_CHECK: begin
                if (byte_vld_s) begin
                    state_d = (byte_s == chk_q) ? ST_DONE : ST_ERROR;
                end else if (expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Status is registered on entry so it appears one cycle after the deciding byte.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d = 1'b1;
            hold_d = 1'b0;
            busy_d = 1'b0;
        end else if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            done_d = done_d;
        end
    end

    // one-entry skid: catches the strobe that lands in the WRITE cycle
    always_comb begin
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        case (state_q)
            ST_WRITE: begin
                if (rx_valid) begin
                    skid_d     = rx_byte;
                    skid_vld_d = 1'b1;
                end else begin
                    skid_vld_d = skid_vld_q;
                end
            end
            ST_SYNC, ST_COUNT, ST_HI, ST_LO, ST_CHECK: begin
                if (skid_vld_q) begin
                    skid_d     = rx_byte;
                    skid_vld_d = rx_valid;
                end else begin
                    skid_vld_d = 1'b0;
                end
            end
            default: skid_vld_d = 1'b0;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR{1'b0}};
            cmd_q      <= {WORD{1'b0}};
            write_q    <= 1'b0;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            chk_q      <= 8'h00;
            hi_q       <= 8'h00;
            cnt_q      <= {(ADDR+1){1'b0}};
            skid_q     <= 8'h00;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            write_q    <= write_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            chk_q      <= chk_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign program_write = write_q;
    assign program_addr  = addr_q;
    assign program_cmd   = cmd_q;
    assign cpu_hold      = hold_q;
    assign load_busy     = busy_q;
    assign load_done     = done_q;
    assign load_error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued, a negedge monitor checks them.
module tb_program_loader;

    localparam int ADDR = 8;
    localparam int CODE = 4;
    localparam int WORD = 12;
    localparam int TOUT = 20;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_start;
    logic            rx_valid;
    logic [7:0]      rx_byte;
    logic            program_write;
    logic [ADDR-1:0] program_addr;
    logic [WORD-1:0] program_cmd;
    logic            cpu_hold;
    logic            load_busy;
    logic            load_done;
    logic            load_error;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR(ADDR), .CODE(CODE), .WORD(WORD), .SYNC(8'hA5), .TIMEOUT(TOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .program_write (program_write),
        .program_addr  (program_addr),
        .program_cmd   (program_cmd),
        .cpu_hold      (cpu_hold),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    logic [19:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        tick();
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [11:0] c);
        exp_q.push_back({a, c});
    endtask

    // write monitor: every program_write strobe must match the oldest queued write
    always @(negedge clk) begin
        if (reset !== 1'b1 && program_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h cmd %0h, expected no write",
                         program_addr, program_cmd);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(program_addr), 32'(e[19:12]));
                check("write_cmd", 32'(program_cmd), 32'(e[11:0]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] bb [7];
        logic [11:0] w;
        logic [7:0] chk;

        reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        tick();
        check("rst_write", 32'(program_write), 32'd0);
        check("rst_addr", 32'(program_addr), 32'd0);
        check("rst_cmd", 32'(program_cmd), 32'd0);
        check("rst_status", 32'({cpu_hold, load_busy, load_done, load_error}), 32'd0);
        reset = 1'b0;
        tick();

        // good load
        start();
        check("start_hold_busy", 32'({cpu_hold, load_busy, load_done}), 32'b110);
        send_gap(8'hA5); send_gap(8'h02);
        expect_wr(8'd0, 12'hABC);
        send_gap(8'h0A); send_gap(8'hBC);
        expect_wr(8'd1, 12'h123);
        send_gap(8'h01); send_gap(8'h23);
        check("good_hold_before_chk", 32'(cpu_hold), 32'd1);
        send(8'h96);
        check("good_done", 32'(load_done), 32'd1);
        check("good_error", 32'(load_error), 32'd0);
        check("good_hold_busy", 32'({cpu_hold, load_busy}), 32'd0);
        check("good_writes_drained", 32'(exp_q.size()), 32'd0);
        tick();

        // bad checksum
        start();
        check("bad_done_cleared", 32'(load_done), 32'd0);
        send_gap(8'hA5); send_gap(8'h02);
        expect_wr(8'd0, 12'hABC);
        send_gap(8'h0A); send_gap(8'hBC);
        expect_wr(8'd1, 12'h123);
        send_gap(8'h01); send_gap(8'h23);
        send(8'h97);
        check("bad_error", 32'(load_error), 32'd1);
        check("bad_done", 32'(load_done), 32'd0);
        check("bad_hold_busy", 32'({cpu_hold, load_busy}), 32'b10);
        check("bad_writes_drained", 32'(exp_q.size()), 32'd0);
        tick();

        // padding violation
        start();
        check("pad_error_cleared", 32'(load_error), 32'd0);
        send_gap(8'hA5); send_gap(8'h01);
        send(8'h1A);
        check("pad_error_before_lo", 32'(load_error), 32'd0);
        send(8'hBC);
        check("pad_error", 32'(load_error), 32'd1);
        check("pad_busy", 32'(load_busy), 32'd0);
        tick(); tick();

        // sync hunt with back-to-back bytes
        bb = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h05, 8'h55, 8'h51};
        start();
        expect_wr(8'd0, 12'h555);
        for (int i = 0; i < 7; i++) begin
            send(bb[i]);
        end
        tick();
        check("b2b_done", 32'(load_done), 32'd1);
        check("b2b_error", 32'(load_error), 32'd0);
        check("b2b_writes_drained", 32'(exp_q.size()), 32'd0);
        tick();

        // inter-byte timeout
        start();
        send_gap(8'hA5); send_gap(8'h03);
        send(8'h0A);
        repeat (TOUT - 1) tick();
        check("tout_not_yet", 32'(load_error), 32'd0);
        tick();
        check("tout_error", 32'(load_error), 32'd1);
        check("tout_hold_busy", 32'({cpu_hold, load_busy}), 32'b10);
        tick();

        // async reset mid-frame, then a full 256-word frame
        start();
        send_gap(8'hA5); send_gap(8'h02);
        expect_wr(8'd0, 12'hABC);
        send_gap(8'h0A); send_gap(8'hBC);
        tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_write", 32'(program_write), 32'd0);
        check("midrst_addr", 32'(program_addr), 32'd0);
        check("midrst_cmd", 32'(program_cmd), 32'd0);
        check("midrst_status", 32'({cpu_hold, load_busy, load_done, load_error}), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        start();
        send_gap(8'hA5); send_gap(8'h00);
        chk = 8'h00;
        for (int i = 0; i < 256; i++) begin
            w = 12'(i * 173 + 9);
            expect_wr(8'(i), w);
            send_gap({4'h0, w[11:8]});
            send_gap(w[7:0]);
            chk = chk ^ {4'h0, w[11:8]} ^ w[7:0];
        end
        send(chk);
        check("full_done", 32'(load_done), 32'd1);
        check("full_error", 32'(load_error), 32'd0);
        check("full_addr_wrap", 32'(program_addr), 32'd0);
        check("full_hold", 32'(cpu_hold), 32'd0);
        check("full_writes_drained", 32'(exp_q.size()), 32'd0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream program loader that sits upstream of the processor's program-write interface.
- Takes bytes from a UART receiver, frames them into WORD-bit instructions and writes them into text RAM.
- Holds the processor in reset for the whole load.
- Validates each frame with a sync byte, a word count, a zero-padding check and an XOR checksum.
- Reports busy/done/error status to the board.

Parameters:
- ADDR, 8: text address width; word count and write address width (ADDR <= 8).
- CODE, 4: opcode width.
- WORD, ADDR+CODE: instruction width (WORD <= 16).
- SYNC, 8'hA5: frame start byte.
- TIMEOUT, 1_000_000: max idle clk cycles between bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- load_start  in  1  one-cycle pulse; arms the loader.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- rx_byte  in  8  received byte.
- program_write  out  1  one-cycle write strobe to text RAM.
- program_addr  out  ADDR  text RAM write address.
- program_cmd  out  WORD  instruction to write.
- cpu_hold  out  1  high = keep processor in reset.
- load_busy  out  1  high while a frame is in progress.
- load_done  out  1  sticky; last frame loaded and checksum OK.
- load_error  out  1  sticky; last frame failed.

Behaviour:
- Reset values: program_write=0, program_addr=0, program_cmd=0, cpu_hold=0, load_busy=0, load_done=0, load_error=0. FSM enters IDLE; checksum, counters and timeout are cleared.
- Frame format: SYNC, N, then N×(HI, LO), then CHK.
  - N = word count; 0 means 2^ADDR words.
  - Each word = {HI,LO}[WORD-1:0]. Bits [15:WORD] of {HI,LO} must be 0.
  - CHK = XOR of N and every HI and LO byte.
- FSM states: IDLE, SYNC, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR.
  - IDLE: rx bytes ignored. On load_start go to SYNC; set cpu_hold=1 and load_busy=1; clear done/error, checksum and address.
  - SYNC: a byte equal to SYNC goes to COUNT. Other bytes are discarded and the FSM stays in SYNC. The timeout is not active in SYNC.
  - COUNT: latch N, checksum ^= N, go to HI.
  - HI: latch HI, checksum ^= HI, go to LO.
  - LO: checksum ^= LO. Nonzero padding bits go to ERROR; otherwise load program_cmd and go to WRITE.
  - WRITE: single cycle with program_write=1 at program_addr. On the next cycle program_addr increments (wraps at 2^ADDR). If remaining words = 0 go to CHECK, else go to HI.
  - CHECK: on the received byte, match goes to DONE and mismatch goes to ERROR.
  - DONE: load_done=1, cpu_hold=0, load_busy=0, then return to IDLE. load_done stays set.
  - ERROR: load_error=1, load_busy=0, cpu_hold stays 1, then return to IDLE. The processor stays halted until a good load or reset.
- Writes have already landed by the time a checksum fails; load_error only marks the text RAM contents as invalid.
- Timeout: in COUNT, HI, LO and CHECK, a cycle counter resets on every rx_valid. When it reaches TIMEOUT the FSM goes to ERROR.
- rx_valid during WRITE: the byte is captured into a one-entry skid register and consumed in the next state. No byte is lost at back-to-back rx rate.
- load_start outside IDLE/SYNC is ignored. load_start in SYNC restarts SYNC.
- Latency: program_write asserts exactly 1 cycle after the LO byte strobe. Status outputs update 1 cycle after the CHK byte strobe.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. cpu_hold drops, so the processor reset is owned by the external reset.

Decomposition:
- New package loader_pkg holds:
  - the state enum loader_state_t;
  - the SYNC default;
  - a checksum function xor8(acc, byte).
- One sub-module, loader_timeout: a loadable down-counter with clear, enable and expired outputs, parameterised by TIMEOUT.

Test Plan:
- Good load: start; bytes A5, 02, 0A,BC, 01,23, CHK=02^0A^BC^01^23=96 -> writes 0xABC@0 and 0x123@1; load_done=1; cpu_hold falls 1 cycle after the CHK strobe.
- Bad checksum: same frame with CHK=97 -> both writes occur; load_error=1; cpu_hold stays 1; load_done=0.
- Padding violation: A5, 01, 1A, BC (WORD=12) -> no write; load_error=1 one cycle after the LO strobe.
- Sync hunt plus back-to-back bytes: bytes 00, FF, A5, 01, 05, 55, 51 on consecutive cycles -> write 0x555@0; done; no byte dropped around the WRITE cycle.
- Timeout: A5, 03, 0A, then silence for TIMEOUT cycles -> load_error=1 at exactly TIMEOUT cycles after the last strobe; no write.
- Async reset mid-frame after 1 word, then a new full frame with N=0 (256 words) -> all outputs 0 immediately on reset; addresses 0..255 written; program_addr wraps to 0; done.
